// File: rtl/udp_payload_fifo_reader.sv
// rtl/udp_payload_fifo_reader.sv - consumer side of the UDP prefetch FIFO: level tracking and tx word feed
module udp_payload_fifo_reader #(
  parameter int PKT_WORDS  = 256,
  parameter int GAP_CYCLES = 16,
  parameter int LVL_W      = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_wr_en,
  input  logic             fifo_wr_vld,
  input  logic             fifo_rd_vld,
  input  logic [31:0]      fifo_rd_data,
  output logic             fifo_rd_en,
  input  logic             tx_req,
  input  logic             tx_done,
  output logic             tx_start_en,
  output logic [15:0]      tx_byte_num,
  output logic [31:0]      tx_data,
  output logic [LVL_W-1:0] fifo_level,
  output logic [15:0]      pkt_cnt,
  output logic             underflow,
  output logic             overflow,
  output logic             busy
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(2048);
  localparam logic [LVL_W-1:0] LVL_PKT = LVL_W'(PKT_WORDS);
  localparam logic [11:0]      WORDS_INIT = 12'(PKT_WORDS);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;

  state_t            state_q, state_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;
  logic              underflow_q, underflow_d;
  logic              overflow_q, overflow_d;
  logic [11:0]       words_left_q, words_left_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [31:0]       tx_data_q, tx_data_d;
  logic              push;
  logic              pop;
  logic              word_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      level_q      <= '0;
      pkt_cnt_q    <= '0;
      underflow_q  <= 1'b0;
      overflow_q   <= 1'b0;
      words_left_q <= '0;
      gap_cnt_q    <= '0;
      tx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      pkt_cnt_q    <= pkt_cnt_d;
      underflow_q  <= underflow_d;
      overflow_q   <= overflow_d;
      words_left_q <= words_left_d;
      gap_cnt_q    <= gap_cnt_d;
      tx_data_q    <= tx_data_d;
    end
  end

  always_comb begin
    push         = fifo_wr_en & fifo_wr_vld;
    word_req     = tx_req && (state_q == SEND) && (words_left_q != 12'd0);
    pop          = word_req & fifo_rd_vld;
    state_d      = state_q;
    level_d      = level_q;
    pkt_cnt_d    = pkt_cnt_q;
    underflow_d  = underflow_q;
    overflow_d   = overflow_q;
    words_left_d = words_left_q;
    gap_cnt_d    = gap_cnt_q;
    tx_data_d    = tx_data_q;

    // Level saturates at both ends; the real FIFO cannot exceed 2048 words.
    if (push && !pop) begin
      if (level_q == LVL_MAX) overflow_d = 1'b1;
      else level_d = level_q + 1'b1;
    end else if (pop && !push && level_q != '0) begin
      level_d = level_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (level_q >= LVL_PKT) state_d = START;
      end
      START: begin
        pkt_cnt_d    = pkt_cnt_q + 16'd1;
        words_left_d = WORDS_INIT;
        state_d      = SEND;
      end
      SEND: begin
        if (word_req) begin
          tx_data_d    = fifo_rd_vld ? fifo_rd_data : 32'h0;
          underflow_d  = underflow_q | ~fifo_rd_vld;
          words_left_d = words_left_q - 12'd1;
        end
        if (tx_done) begin
          gap_cnt_d = '0;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
        else gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_rd_en  = pop;
  assign tx_start_en = (state_q == START);
  assign tx_byte_num = 16'(PKT_WORDS * 4);
  assign tx_data     = tx_data_q;
  assign fifo_level  = level_q;
  assign pkt_cnt     = pkt_cnt_q;
  assign underflow   = underflow_q;
  assign overflow    = overflow_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_udp_payload_fifo_reader.sv
// tb/tb_udp_payload_fifo_reader.sv - randomized bench with queue-based FIFO and level/word reference model
module tb_udp_payload_fifo_reader;
  localparam int P = 4;
  localparam int G = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_wr_en, fifo_wr_vld, fifo_rd_vld, fifo_rd_en;
  logic [31:0] fifo_rd_data, tx_data;
  logic        tx_req, tx_done, tx_start_en, underflow, overflow, busy;
  logic [15:0] tx_byte_num, pkt_cnt;
  logic [11:0] fifo_level;

  udp_payload_fifo_reader #(.PKT_WORDS(P), .GAP_CYCLES(G), .LVL_W(12)) dut (
    .clk(clk), .rst(rst), .fifo_wr_en(fifo_wr_en), .fifo_wr_vld(fifo_wr_vld),
    .fifo_rd_vld(fifo_rd_vld), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .tx_req(tx_req), .tx_done(tx_done), .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num),
    .tx_data(tx_data), .fifo_level(fifo_level), .pkt_cnt(pkt_cnt), .underflow(underflow),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];
  bit          force_empty;
  int          exp_lvl, exp_pkt, left, cyc, start_cyc, n_starts, last_push, done_cyc, p1;
  bit          exp_uf, exp_of, in_frame, start_seen;
  logic [31:0] exp_txd;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive_head();
    fifo_rd_vld  = (q.size() != 0) && !force_empty;
    fifo_rd_data = (q.size() != 0) ? q[0] : 32'h0;
  endtask

  task automatic tick_cycle(input bit push, input logic [31:0] wd, input bit req, input bit done);
    bit          exp_pop, obs_pop, st, vld;
    logic [31:0] head;
    fifo_wr_en = push;
    tx_req     = req;
    tx_done    = done;
    drive_head();
    #1;
    vld     = fifo_rd_vld;
    head    = fifo_rd_data;
    exp_pop = req && vld && in_frame && left > 0;
    chk("rd_en", {31'b0, fifo_rd_en}, {31'b0, exp_pop});
    obs_pop = fifo_rd_en;
    st      = tx_start_en;
    @(posedge clk);
    cyc++;
    if (obs_pop && q.size() != 0) void'(q.pop_front());
    if (push) q.push_back(wd);
    if (push && !exp_pop) begin
      if (exp_lvl == 2048) exp_of = 1'b1;
      else exp_lvl++;
    end else if (!push && exp_pop && exp_lvl > 0) begin
      exp_lvl--;
    end
    if (in_frame && req && left > 0) begin
      exp_txd = vld ? head : 32'h0;
      if (!vld) exp_uf = 1'b1;
      left--;
    end
    if (in_frame && done) in_frame = 1'b0;
    if (st) begin
      start_seen = 1'b1;
      start_cyc  = cyc - 1;
      n_starts++;
      in_frame   = 1'b1;
      left       = P;
      exp_pkt++;
    end
    #1;
    chk("level", {20'b0, fifo_level}, exp_lvl);
    chk("tx_data", tx_data, exp_txd);
    chk("underflow", {31'b0, underflow}, {31'b0, exp_uf});
    chk("overflow", {31'b0, overflow}, {31'b0, exp_of});
    chk("pkt_cnt", {16'b0, pkt_cnt}, exp_pkt & 32'hffff);
    tx_req  = 1'b0;
    tx_done = 1'b0;
    drive_head();
  endtask

  task automatic idle(input int n);
    repeat (n) tick_cycle(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      tick_cycle(1'b1, $urandom, 1'b0, 1'b0);
      last_push = cyc - 1;
    end
  endtask

  task automatic wait_start(input int bound);
    for (int i = 0; i < bound && !start_seen; i++) idle(1);
    chk("start_seen", {31'b0, start_seen}, 32'd1);
  endtask

  task automatic serve(input int n, input bit with_push);
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, 2));
      tick_cycle(with_push, $urandom, 1'b1, 1'b0);
    end
  endtask

  task automatic done_pulse();
    tick_cycle(1'b0, 32'h0, 1'b0, 1'b1);
    done_cyc = cyc - 1;
  endtask

  initial begin
    rst = 1'b1;
    fifo_wr_en = 1'b0; fifo_wr_vld = 1'b1; tx_req = 1'b0; tx_done = 1'b0;
    force_empty = 1'b0; q.delete(); drive_head();
    exp_lvl = 0; exp_pkt = 0; left = 0; cyc = 0; n_starts = 0;
    exp_uf = 0; exp_of = 0; in_frame = 0; start_seen = 0; exp_txd = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start", {31'b0, tx_start_en}, 32'd0);
    chk("rst_level", {20'b0, fifo_level}, 32'd0);
    chk("rst_pkt", {16'b0, pkt_cnt}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_txd", tx_data, 32'd0);
    chk("rst_flags", {30'b0, underflow, overflow}, 32'd0);
    chk("byte_num", {16'b0, tx_byte_num}, P * 4);
    #1 rst = 1'b0;

    // one packet with the reference words
    for (int i = 1; i <= 4; i++) begin
      tick_cycle(1'b1, 32'h11 * i, 1'b0, 1'b0);
      last_push = cyc - 1;
    end
    wait_start(8);
    chk("start_lat", start_cyc - last_push, 32'd2);
    chk("start_pulse", {31'b0, tx_start_en}, 32'd0);
    chk("busy_send", {31'b0, busy}, 32'd1);
    serve(4, 1'b0);
    chk("last_word", tx_data, 32'h44);
    done_pulse();
    for (int i = 0; i < G; i++) begin
      chk("busy_gap", {31'b0, busy}, 32'd1);
      idle(1);
    end
    chk("busy_idle", {31'b0, busy}, 32'd0);

    // short of a packet; stray req/done in IDLE
    start_seen = 1'b0;
    push_words(3);
    tick_cycle(1'b0, 32'h0, 1'b1, 1'b1);
    idle(8);
    chk("no_start", {31'b0, start_seen}, 32'd0);
    chk("busy_short", {31'b0, busy}, 32'd0);

    // underflow: one good word then FIFO reports empty
    push_words(1);
    wait_start(8);
    serve(1, 1'b0);
    force_empty = 1'b1;
    serve(5, 1'b0);
    chk("uf_flag", {31'b0, underflow}, 32'd1);
    chk("uf_level", {20'b0, fifo_level}, 32'd3);
    force_empty = 1'b0;
    start_seen = 1'b0;
    done_pulse();
    idle(G + 6);
    chk("uf_no_restart", {31'b0, start_seen}, 32'd0);

    // two back-to-back packets
    push_words(1);
    p1 = last_push;
    push_words(4);
    wait_start(8);
    chk("start_lat2", start_cyc - p1, 32'd2);
    serve(4, 1'b0);
    start_seen = 1'b0;
    done_pulse();
    wait_start(G + 6);
    chk("gap_spacing", start_cyc - done_cyc, G + 2);
    serve(4, 1'b1);
    chk("pushpop_level", {20'b0, fifo_level}, 32'd4);
    chk("pkt_cnt4", {16'b0, pkt_cnt}, 32'd4);
    start_seen = 1'b0;
    done_pulse();

    // async reset in the middle of SEND
    wait_start(G + 6);
    serve(2, 1'b0);
    #2 rst = 1'b1;
    tx_req = 1'b1;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_level", {20'b0, fifo_level}, 32'd0);
    chk("arst_pkt", {16'b0, pkt_cnt}, 32'd0);
    chk("arst_txd", tx_data, 32'd0);
    chk("arst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
    chk("arst_flags", {29'b0, underflow, overflow, tx_start_en}, 32'd0);
    q.delete(); exp_lvl = 0; exp_pkt = 0; exp_uf = 0; exp_of = 0;
    in_frame = 0; left = 0; exp_txd = 32'h0; tx_req = 1'b0;
    @(posedge clk);
    cyc++;
    #2 rst = 1'b0;
    start_seen = 1'b0;
    push_words(3);
    idle(5);
    chk("arst_no_start", {31'b0, start_seen}, 32'd0);
    push_words(1);
    wait_start(8);
    chk("arst_start_lat", start_cyc - last_push, 32'd2);

    // fill to 2048, then one push beyond, then push+pop at full
    push_words(2044);
    chk("full_level", {20'b0, fifo_level}, 32'd2048);
    chk("full_no_of", {31'b0, overflow}, 32'd0);
    push_words(1);
    chk("of_flag", {31'b0, overflow}, 32'd1);
    chk("of_level", {20'b0, fifo_level}, 32'd2048);
    tick_cycle(1'b1, $urandom, 1'b1, 1'b0);
    chk("full_pushpop", {20'b0, fifo_level}, 32'd2048);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
